l2_rr_arbiter: RTL and testbench
================================

Name: l2_rr_arbiter

Overview:
- Round-robin arbiter that shares the single L2 request port among NREQ L1-side requesters (icache, dcache, uncached/TLB walker).
- Each requester uses the pulse-request / busy-stall burst protocol of the L1 caches.
- Captures pulses that arrive while the port is occupied.
- Issues one L2 burst at a time, counts beats, and returns the port fairly.

Parameters:
- NREQ, 3, number of requesters (2..4).
- ADDR_W, 32, address width.
- DATA_W, 32, write data width.
- BURST_W, 5, burst length field width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_rreq  in  NREQ  one-cycle read request pulse, one bit per requester.
- req_wreq  in  NREQ  one-cycle write request pulse, one bit per requester.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i occupies slice i.
- req_burst  in  NREQ*BURST_W  packed burst lengths in words; 0 means 2^BURST_W.
- req_wdata  in  NREQ*DATA_W  packed write data, sampled per beat.
- req_busy  out  NREQ  per-requester stall; 0 means a beat completes this cycle.
- grant_id  out  2  index of the current owner; valid when l2_active=1.
- l2_active  out  1  high in ISSUE and XFER.
- l2_rreq  out  1  one-cycle L2 read pulse.
- l2_wreq  out  1  one-cycle L2 write pulse.
- l2_addr  out  ADDR_W  registered burst start address.
- l2_burst_size  out  BURST_W  registered burst length.
- l2_wdata  out  DATA_W  = req_wdata slice of grant_id (combinational).
- l2_busy  in  1  L2 stall; 0 means beat accepted or returned.

Behaviour:
- Reset values:
  - state=IDLE, pending_r/pending_w all 0, rr_ptr=0, grant_id=0.
  - l2_rreq=l2_wreq=0, l2_addr=0, l2_burst_size=0, beat counter=0.
  - req_busy all 1.
  - Reset asserted mid-burst aborts immediately; the L2 side is the owner's responsibility.
- Capture:
  - A pulse on requester i sets pending_r[i] or pending_w[i].
  - The pulse latches addr_i and burst_i into per-requester holding registers.
  - If rreq and wreq pulse together, read wins and the write pulse is dropped.
  - Pulses while pending[i] is set, or while i is the owner, are ignored (protocol violation).
- Eligible set E = pending | live pulses, so a same-cycle pulse is arbitrated without a capture delay.
  - A live pulse supplies its own addr/burst.
  - A pending entry supplies the held values.
- States:
  - IDLE: if E≠0, pick the first set index searching from rr_ptr upward (wrapping modulo NREQ).
    - On the grant edge: grant_id←winner; l2_rreq or l2_wreq←1; l2_addr/l2_burst_size←winner values.
    - Also on that edge: beat counter←burst (0 loads 0 and is treated as 2^BURST_W); clear the winner's pending bits; go to ISSUE.
  - ISSUE (1 cycle): l2_rreq=l2_wreq←0; go to XFER.
  - XFER: req_busy[grant_id]=l2_busy; every other req_busy=1.
    - On ~l2_busy: counter←counter-1, modulo 2^BURST_W.
    - When ~l2_busy and counter==1: go to IDLE and set rr_ptr←(grant_id+1) mod NREQ.
- Latency: pulse at edge T; l2_rreq is high during cycle T+1 when the port is idle; the first beat can complete in cycle T+2.
- Back-to-back: there is no idle bubble beyond the IDLE cycle; the next grant occurs on the edge leaving IDLE.
- Outside XFER, all req_busy=1.
- l2_active=1 in ISSUE and XFER.

Decomposition:
- Package l2_arb_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, XFER=2'd2) and function rr_pick(vec, ptr).
- One sub-module, l2_req_capture, instantiated NREQ times. It holds the pending bits, addr, and burst for one requester.
- The top level holds the FSM, rr_ptr, counter, and muxes.

Test Plan:
1. Idle port, requester 1 read pulse, addr 0x1000, burst 4, l2_busy low after ISSUE:
   - l2_rreq is a one-cycle pulse with l2_addr=0x1000 and l2_burst_size=4.
   - req_busy[1] is low for 4 cycles, then the FSM returns to IDLE and rr_ptr=2.
2. Reads pulse from requesters 0, 1 and 2 in the same cycle, rr_ptr=0:
   - Grants occur in the order 0, 1, 2, each with its own address.
   - Requesters 1 and 2 are served from pending.
   - No burst overlaps another; rr_ptr ends at 0.
3. Requester 2 write pulses during requester 0's 8-beat burst:
   - pending_w[2] is set.
   - l2_wreq fires on the edge after requester 0's last beat.
   - l2_wdata follows req_wdata slice 2.
4. Burst 0 with l2_busy toggling 1,0,1,0…: exactly 32 beats complete, with req_busy tracking l2_busy.
5. rreq and wreq on requester 1 in the same cycle: only l2_rreq is issued, and pending_w[1] stays 0.
6. reset asserted in XFER mid-burst:
   - On the asynchronous assertion, state=IDLE, l2_rreq=0, l2_wreq=0, req_busy all 1 and pending cleared.
   - After release, a new request is granted normally.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared FSM encoding and round-robin pick helper for the L2 port arbiter
package l2_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, XFER = 2'd2} state_t;
  // First set bit of vec at or after ptr, wrapping modulo n (n <= 4, ptr < n)
  function automatic logic [1:0] rr_pick(input logic [3:0] vec, input logic [1:0] ptr, input logic [2:0] n);
    logic [1:0] r;
    logic f;
    logic [2:0] idx;
    r = '0;
    f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= n) idx = idx - n;
      if (3'(k) < n && !f && vec[idx[1:0]]) begin
        r = idx[1:0];
        f = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/l2_req_capture.sv
// l2_req_capture: holds one requester's pending read/write flag and its latched addr/burst
module l2_req_capture #(
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_rreq,
  input  logic               i_wreq,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [BURST_W-1:0] i_burst,
  input  logic               i_owner,
  input  logic               i_clr,
  output logic               o_elig_r,
  output logic               o_elig_w,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [BURST_W-1:0] o_burst
);
  logic               r_pend_r, r_pend_w;
  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_burst;
  logic               w_pend, w_acc;
  assign w_pend   = r_pend_r | r_pend_w;
  // Pulses from a requester already queued or currently owning the port are dropped
  assign w_acc    = (i_rreq | i_wreq) & ~w_pend & ~i_owner;
  assign o_elig_r = r_pend_r | (w_acc & i_rreq);
  assign o_elig_w = r_pend_w | (w_acc & ~i_rreq & i_wreq);
  assign o_addr   = w_pend ? r_addr : i_addr;
  assign o_burst  = w_pend ? r_burst : i_burst;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_r <= 1'b0;
      r_pend_w <= 1'b0;
      r_addr   <= '0;
      r_burst  <= '0;
    end else begin
      if (i_clr) begin
        r_pend_r <= 1'b0;
        r_pend_w <= 1'b0;
      end else if (w_acc) begin
        r_pend_r <= i_rreq;
        r_pend_w <= ~i_rreq & i_wreq;
      end
      if (w_acc) begin
        r_addr  <= i_addr;
        r_burst <= i_burst;
      end
    end
  end
endmodule

// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: round-robin sharing of one L2 burst port among NREQ pulse/busy requesters
module l2_rr_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_rreq,
  input  logic [NREQ-1:0]         req_wreq,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*BURST_W-1:0] req_burst,
  input  logic [NREQ*DATA_W-1:0]  req_wdata,
  output logic [NREQ-1:0]         req_busy,
  output logic [1:0]              grant_id,
  output logic                    l2_active,
  output logic                    l2_rreq,
  output logic                    l2_wreq,
  output logic [ADDR_W-1:0]       l2_addr,
  output logic [BURST_W-1:0]      l2_burst_size,
  output logic [DATA_W-1:0]       l2_wdata,
  input  logic                    l2_busy
);
  state_t             r_state;
  logic [1:0]         r_ptr;
  logic [BURST_W-1:0] r_cnt;
  logic [NREQ-1:0]    w_er, w_ew, w_own, w_clr;
  logic [ADDR_W-1:0]  w_addr [NREQ];
  logic [BURST_W-1:0] w_burst [NREQ];
  logic [DATA_W-1:0]  w_wd [NREQ];
  logic [3:0]         w_e4;
  logic [1:0]         w_win;
  logic               w_go;
  for (genvar i = 0; i < NREQ; i++) begin : g_cap
    assign w_own[i]    = l2_active && grant_id == 2'(i);
    assign w_clr[i]    = w_go && w_win == 2'(i);
    assign w_wd[i]     = req_wdata[i*DATA_W +: DATA_W];
    assign req_busy[i] = (r_state == XFER && grant_id == 2'(i)) ? l2_busy : 1'b1;
    l2_req_capture #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) u_cap (
      .clk      (clk),
      .reset    (reset),
      .i_rreq   (req_rreq[i]),
      .i_wreq   (req_wreq[i]),
      .i_addr   (req_addr[i*ADDR_W +: ADDR_W]),
      .i_burst  (req_burst[i*BURST_W +: BURST_W]),
      .i_owner  (w_own[i]),
      .i_clr    (w_clr[i]),
      .o_elig_r (w_er[i]),
      .o_elig_w (w_ew[i]),
      .o_addr   (w_addr[i]),
      .o_burst  (w_burst[i])
    );
  end
  // Live pulses join the pending set so an idle port grants without a capture cycle
  assign w_e4      = 4'(w_er | w_ew);
  assign w_win     = rr_pick(w_e4, r_ptr, 3'(NREQ));
  assign w_go      = r_state == IDLE && |w_e4;
  assign l2_active = r_state != IDLE;
  assign l2_wdata  = w_wd[grant_id];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      grant_id      <= '0;
      l2_rreq       <= 1'b0;
      l2_wreq       <= 1'b0;
      l2_addr       <= '0;
      l2_burst_size <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          grant_id      <= w_win;
          l2_rreq       <= w_er[w_win];
          l2_wreq       <= ~w_er[w_win];
          l2_addr       <= w_addr[w_win];
          l2_burst_size <= w_burst[w_win];
          r_cnt         <= w_burst[w_win];
          r_state       <= ISSUE;
        end
        ISSUE: begin
          l2_rreq <= 1'b0;
          l2_wreq <= 1'b0;
          r_state <= XFER;
        end
        XFER: if (!l2_busy) begin
          // A zero burst wraps through 2^BURST_W beats before reaching 1
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == BURST_W'(1)) begin
            r_state <= IDLE;
            r_ptr   <= grant_id == 2'(NREQ - 1) ? 2'd0 : grant_id + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_rr_arbiter.sv
// tb_l2_rr_arbiter: directed checks of grant order, burst beats, capture and async reset
module tb_l2_rr_arbiter;
  localparam int NREQ = 3, AW = 32, DW = 32, BW = 5;
  logic              clk = 1'b0, reset = 1'b0;
  logic [NREQ-1:0]   req_rreq = '0, req_wreq = '0, req_busy;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*BW-1:0] req_burst = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [1:0]        grant_id;
  logic              l2_active, l2_rreq, l2_wreq, l2_busy = 1'b0;
  logic [AW-1:0]     l2_addr;
  logic [BW-1:0]     l2_burst_size;
  logic [DW-1:0]     l2_wdata;
  int n_chk = 0, n_err = 0, busy_mode = 0;
  always #5 clk = ~clk;
  l2_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk(clk), .reset(reset), .req_rreq(req_rreq), .req_wreq(req_wreq),
    .req_addr(req_addr), .req_burst(req_burst), .req_wdata(req_wdata),
    .req_busy(req_busy), .grant_id(grant_id), .l2_active(l2_active),
    .l2_rreq(l2_rreq), .l2_wreq(l2_wreq), .l2_addr(l2_addr),
    .l2_burst_size(l2_burst_size), .l2_wdata(l2_wdata), .l2_busy(l2_busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic stepc();
    @(negedge clk);
    req_rreq  = '0;
    req_wreq  = '0;
    l2_busy   = busy_mode != 0 ? ~l2_busy : 1'b0;
    req_wdata = {$urandom, $urandom, $urandom};
    #1;
  endtask
  task automatic set_req(input int id, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_addr[id*AW +: AW]  = a;
    req_burst[id*BW +: BW] = b;
  endtask
  task automatic check_idle_reset(input string tag);
    chk({tag, "_active"}, l2_active, 0);
    chk({tag, "_rreq"}, l2_rreq, 0);
    chk({tag, "_wreq"}, l2_wreq, 0);
    chk({tag, "_busy"}, req_busy, 3'b111);
    chk({tag, "_addr"}, l2_addr, 0);
    chk({tag, "_bsz"}, l2_burst_size, 0);
    chk({tag, "_gid"}, grant_id, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_idle_reset("rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask
  task automatic expect_grant(input string tag, input int id, input bit rd,
                              input logic [AW-1:0] a, input logic [BW-1:0] b, input int lim);
    int n;
    for (n = 0; n < lim; n++) begin
      stepc();
      if (l2_rreq | l2_wreq) break;
    end
    chk({tag, "_seen"}, n < lim, 1);
    if (n < lim) begin
      chk({tag, "_gid"}, grant_id, id);
      chk({tag, "_rreq"}, l2_rreq, rd);
      chk({tag, "_wreq"}, l2_wreq, !rd);
      chk({tag, "_addr"}, l2_addr, a);
      chk({tag, "_bsz"}, l2_burst_size, b);
      chk({tag, "_issbusy"}, req_busy, 3'b111);
    end
  endtask
  task automatic run_burst(input string tag, input int id, input int mode, input int exp_beats,
                           input logic [NREQ-1:0] inj_r, input logic [NREQ-1:0] inj_w);
    int beats = 0;
    logic [NREQ-1:0] eb;
    busy_mode = mode;
    l2_busy   = 1'b0;
    for (int c = 0; c < 100; c++) begin
      stepc();
      if (!l2_active) break;
      eb     = '1;
      eb[id] = l2_busy;
      chk({tag, "_rbusy"}, req_busy, eb);
      chk({tag, "_nopulse"}, l2_rreq | l2_wreq, 0);
      chk({tag, "_wdata"}, l2_wdata, req_wdata[id*DW +: DW]);
      if (!l2_busy) beats++;
      if (c == 2) begin
        req_rreq = inj_r;
        req_wreq = inj_w;
      end
    end
    busy_mode = 0;
    chk({tag, "_beats"}, beats, exp_beats);
    chk({tag, "_done"}, l2_active, 0);
  endtask
  task automatic no_grant(input string tag, input int ncyc);
    int g = 0;
    for (int c = 0; c < ncyc; c++) begin
      stepc();
      if (l2_rreq | l2_wreq | l2_active) g++;
    end
    chk({tag, "_none"}, g, 0);
  endtask
  initial begin
    #1 reset = 1'b1;
    #1 check_idle_reset("init");
    @(negedge clk);
    reset = 1'b0;
    #1;
    set_req(1, 32'h1000, 5'd4);
    req_rreq = 3'b010;
    expect_grant("t1", 1, 1, 32'h1000, 5'd4, 1);
    run_burst("t1", 1, 0, 4, '0, '0);
    set_req(0, 32'h2000, 5'd2);
    set_req(2, 32'h3000, 5'd3);
    req_rreq = 3'b101;
    expect_grant("ptr2a", 2, 1, 32'h3000, 5'd3, 1);
    run_burst("ptr2a", 2, 0, 3, '0, '0);
    expect_grant("ptr2b", 0, 1, 32'h2000, 5'd2, 1);
    run_burst("ptr2b", 0, 0, 2, '0, '0);
    do_reset();
    set_req(0, 32'hA000, 5'd2);
    set_req(1, 32'hB000, 5'd3);
    set_req(2, 32'hC000, 5'd1);
    req_rreq = 3'b111;
    expect_grant("t2g0", 0, 1, 32'hA000, 5'd2, 1);
    req_addr  = '1;
    req_burst = '1;
    run_burst("t2g0", 0, 0, 2, '0, '0);
    expect_grant("t2g1", 1, 1, 32'hB000, 5'd3, 1);
    run_burst("t2g1", 1, 0, 3, '0, '0);
    expect_grant("t2g2", 2, 1, 32'hC000, 5'd1, 1);
    run_burst("t2g2", 2, 0, 1, '0, '0);
    set_req(0, 32'hD000, 5'd1);
    set_req(1, 32'hE000, 5'd1);
    req_rreq = 3'b011;
    expect_grant("t2p0", 0, 1, 32'hD000, 5'd1, 1);
    run_burst("t2p0", 0, 0, 1, '0, '0);
    expect_grant("t2p1", 1, 1, 32'hE000, 5'd1, 1);
    run_burst("t2p1", 1, 0, 1, '0, '0);
    set_req(0, 32'h4000, 5'd8);
    req_rreq = 3'b001;
    expect_grant("t3r", 0, 1, 32'h4000, 5'd8, 1);
    set_req(2, 32'h5000, 5'd2);
    run_burst("t3r", 0, 0, 8, '0, 3'b100);
    expect_grant("t3w", 2, 0, 32'h5000, 5'd2, 1);
    run_burst("t3w", 2, 0, 2, '0, '0);
    set_req(1, 32'h6000, 5'd0);
    req_rreq = 3'b010;
    expect_grant("t4", 1, 1, 32'h6000, 5'd0, 1);
    run_burst("t4", 1, 1, 32, '0, '0);
    set_req(0, 32'h7100, 5'd3);
    req_rreq = 3'b001;
    expect_grant("t5a", 0, 1, 32'h7100, 5'd3, 1);
    set_req(1, 32'h7000, 5'd2);
    run_burst("t5a", 0, 0, 3, 3'b010, 3'b010);
    expect_grant("t5b", 1, 1, 32'h7000, 5'd2, 1);
    run_burst("t5b", 1, 0, 2, '0, '0);
    no_grant("t5", 5);
    set_req(0, 32'h8000, 5'd8);
    req_rreq = 3'b001;
    expect_grant("t6", 0, 1, 32'h8000, 5'd8, 1);
    stepc();
    stepc();
    set_req(2, 32'h8800, 5'd2);
    req_wreq = 3'b100;
    stepc();
    chk("t6_midburst", l2_active, 1);
    #2 reset = 1'b1;
    #1 check_idle_reset("t6rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    no_grant("t6pend", 4);
    set_req(1, 32'h9000, 5'd1);
    req_rreq = 3'b010;
    expect_grant("t6new", 1, 1, 32'h9000, 5'd1, 1);
    run_burst("t6new", 1, 0, 1, '0, '0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
